// File: rtl/seg_pkg.sv
// Shared types for the seven-segment scan driver: digit index, scan state, digit-select helper.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam int         DIGITS  = 8;

  typedef logic [2:0] digit_t;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  // Active-low one-cold select for a single digit.
  function automatic logic [7:0] digit_sel(input digit_t d);
    return ~(8'b0000_0001 << d);
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-digit slot counter: counts 0..SCAN_DIV-1, flags end of blanking and end of slot.
// o_slot_last is a look-ahead strobe: the next cycle is the last one of the slot.
module slot_timer #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_blank_end,
  output logic o_slot_end,
  output logic o_slot_last
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST_CNT  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  assign o_slot_end  = (r_cnt == LAST_CNT);
  assign o_blank_end = (r_cnt == BLANK_END);
  assign o_slot_last = (w_cnt_next == LAST_CNT);

  always_comb begin
    w_cnt_next = r_cnt + 1'b1;
    if (i_clr || o_slot_end) begin
      w_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver, digit 7 first, with a blanking gap per slot.
// Outputs are registered from next-state values; the frame is latched once per scan.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [8*DIGITS-1:0]   display,
  output logic [7:0]            led_cx,
  output logic [7:0]            led_en,
  output logic                  frame_done
);

  state_t              r_state;
  digit_t              r_digit;
  logic [8*DIGITS-1:0] r_shadow;

  state_t     w_next_state;
  digit_t     w_digit_next;
  logic       w_latch;
  logic       w_clr;
  logic       w_blank_end;
  logic       w_slot_end;
  logic       w_slot_last;
  logic [7:0] w_cx_next;
  logic [7:0] w_en_next;
  logic       w_fd_next;

  assign w_clr = !en || (r_state == IDLE);

  slot_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_clr),
    .o_blank_end (w_blank_end),
    .o_slot_end  (w_slot_end),
    .o_slot_last (w_slot_last)
  );

  always_comb begin
    w_next_state = r_state;
    w_digit_next = r_digit;
    w_latch      = 1'b0;
    if (!en) begin
      w_next_state = IDLE;
      w_digit_next = 3'd7;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_next_state = BLANK;
          w_digit_next = 3'd7;
          w_latch      = 1'b1;
        end
        BLANK: begin
          if (w_blank_end) w_next_state = SHOW;
        end
        SHOW: begin
          if (w_slot_end) begin
            w_next_state = BLANK;
            w_digit_next = r_digit - 3'd1;
            w_latch      = (r_digit == 3'd0);
          end
        end
        default: begin
          w_next_state = IDLE;
          w_digit_next = 3'd7;
        end
      endcase
    end
  end

  // The shadow only reloads on transitions into BLANK, so it is stable whenever SHOW is next.
  always_comb begin
    w_cx_next = SEG_OFF;
    w_en_next = SEG_OFF;
    w_fd_next = 1'b0;
    if (w_next_state == SHOW) begin
      w_cx_next = r_shadow[{w_digit_next, 3'b000} +: 8];
      w_en_next = digit_sel(w_digit_next);
      w_fd_next = w_slot_last && (w_digit_next == 3'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_digit    <= 3'd7;
      r_shadow   <= {DIGITS{SEG_OFF}};
      led_cx     <= SEG_OFF;
      led_en     <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_digit    <= w_digit_next;
      if (w_latch) r_shadow <= display;
      led_cx     <= w_cx_next;
      led_en     <= w_en_next;
      frame_done <= w_fd_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLANK_CYCLES=1 (32-cycle frames).
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [63:0] display = 64'h0;
  logic [7:0]  led_cx;
  logic [7:0]  led_en;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;
  bit inv_on   = 1'b0;

  localparam logic [63:0] PAT_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PAT_C = {8{8'hC0}};

  seg_scan_driver #(
    .SCAN_DIV     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .display    (display),
    .led_cx     (led_cx),
    .led_en     (led_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [7:0] e_en, input logic [7:0] e_cx,
                      input logic e_fd);
    chk({tag, "_en"}, {56'h0, led_en}, {56'h0, e_en});
    chk({tag, "_cx"}, {56'h0, led_cx}, {56'h0, e_cx});
    chk({tag, "_fd"}, {63'h0, frame_done}, {63'h0, e_fd});
  endtask

  task automatic step(input string tag, input logic [7:0] e_en, input logic [7:0] e_cx,
                      input logic e_fd);
    @(posedge clk);
    @(negedge clk);
    outs(tag, e_en, e_cx, e_fd);
  endtask

  // One digit slot: one blank edge then three lit edges; frame_done on digit 0's last edge.
  task automatic slot(input string tag, input int d, input logic [7:0] b);
    logic [7:0] sel;
    sel = ~(8'h01 << d);
    step({tag, "_blank"}, 8'hFF, 8'hFF, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step({tag, "_lit"}, sel, b, (d == 0) && (i == 3));
    end
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      chk("inv_onecold", {63'h0, ($countones(~led_en) <= 1)}, 64'h1);
      chk("inv_blank_cx", {56'h0, (led_en == 8'hFF) ? led_cx : 8'hFF}, 64'hFF);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pat;
    en      = 1'b1;
    display = PAT_A;
    #1 rst  = 1'b0;
    inv_on  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs("reset", 8'hFF, 8'hFF, 1'b0);
    end
    rst = 1'b1;

    // Frame 1 with a display change during digit 5's slot; frame 2 must show the new bytes.
    pat = PAT_A;
    for (int d = 7; d >= 0; d--) begin
      logic [7:0] sel;
      sel = ~(8'h01 << d);
      step("f1_blank", 8'hFF, 8'hFF, 1'b0);
      for (int i = 1; i <= 3; i++) begin
        step("f1_lit", sel, pat[d*8 +: 8], (d == 0) && (i == 3));
        if (d == 5 && i == 1) display = PAT_C;
      end
    end
    for (int d = 7; d >= 0; d--) slot("f2", d, 8'hC0);

    // Disable during digit 3's SHOW, then re-enable with new data.
    for (int d = 7; d >= 4; d--) slot("f3", d, 8'hC0);
    step("f3_d3_blank", 8'hFF, 8'hFF, 1'b0);
    step("f3_d3_lit", 8'hF7, 8'hC0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("dis", 8'hFF, 8'hFF, 1'b0);
    display = PAT_A;
    en      = 1'b1;
    step("reen_blank", 8'hFF, 8'hFF, 1'b0);
    step("reen_d7", 8'h7F, 8'h01, 1'b0);
    step("reen_d7b", 8'h7F, 8'h01, 1'b0);

    // Asynchronous reset pulse entirely between edges.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 outs("arst", 8'hFF, 8'hFF, 1'b0);
    #1 rst = 1'b1;
    step("arst_blank", 8'hFF, 8'hFF, 1'b0);
    step("arst_d7", 8'h7F, 8'h01, 1'b0);
    step("arst_d7b", 8'h7F, 8'h01, 1'b0);
    step("arst_d7c", 8'h7F, 8'h01, 1'b0);
    slot("arst_d6", 6, 8'h23);

    inv_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
